// File: rtl/micro_ctrl_if.sv
// GPIO command decoder that sequences length setup, memory load, processing and result readback.
// Latency: command effects one cycle after accept; no backpressure, only enable rising edges are accepted.
module micro_ctrl_if #(
    parameter int NB_GPIO  = 32,
    parameter int NB_DATA  = 13,
    parameter int NB_IMAGE = 10
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic [NB_GPIO-1:0]  i_gpio_data,
    input  logic                i_EoP,
    input  logic [NB_DATA-1:0]  i_readData,
    output logic [NB_GPIO-1:0]  o_gpio_data,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic [NB_DATA-1:0]  o_dataToMem
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_PROC = 2'b10,
        S_READ = 2'b11
    } state_t;

    localparam logic [2:0] OP_SET_LEN    = 3'b001;
    localparam logic [2:0] OP_LOAD_START = 3'b010;
    localparam logic [2:0] OP_LOAD_WORD  = 3'b011;
    localparam logic [2:0] OP_LOAD_END   = 3'b100;
    localparam logic [2:0] OP_PROC_START = 3'b101;
    localparam logic [2:0] OP_READ_WORD  = 3'b110;
    localparam logic [2:0] OP_SOFT_RST   = 3'b111;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [NB_DATA-1:0]  pay_q, pay_d;
    logic                en_q, en_d;
    logic                en_prev_q, en_prev_d;
    logic                armed_q, armed_d;
    logic                eop_q, eop_d;
    logic                load_q, load_d;
    logic                sop_q, sop_d;
    logic                valid_q, valid_d;
    logic [NB_IMAGE-1:0] len_q, len_d;
    logic [NB_DATA-1:0]  data_q, data_d;
    logic [NB_IMAGE-1:0] cnt_q, cnt_d;
    logic [1:0]          rd_stg_q, rd_stg_d;
    logic [NB_DATA-1:0]  rdata_q, rdata_d;
    logic                accept;
    logic                unused_gpio_bits;

    assign unused_gpio_bits = ^{i_gpio_data[28:24], i_gpio_data[22:NB_DATA]};

    // armed_q blocks a stale high enable after reset from counting as an edge
    assign accept = armed_q & en_q & ~en_prev_q;

    always_comb begin
        op_d      = i_gpio_data[31:29];
        pay_d     = i_gpio_data[NB_DATA-1:0];
        en_d      = i_gpio_data[23];
        en_prev_d = en_q;
        armed_d   = armed_q | ~i_gpio_data[23];
        eop_d     = i_EoP;
        state_d   = state_q;
        load_d    = load_q;
        sop_d     = sop_q;
        valid_d   = 1'b0;
        len_d     = len_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        rd_stg_d  = {rd_stg_q[0], 1'b0};
        rdata_d   = rdata_q;

        // Memory answers one cycle after the read strobe; capture it one cycle later
        if (rd_stg_q[1]) begin
            rdata_d = i_readData;
        end

        if (accept && op_q == OP_SOFT_RST) begin
            state_d = S_IDLE;
            load_d  = 1'b0;
            sop_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (op_q == OP_SET_LEN) begin
                            len_d = pay_q[NB_IMAGE-1:0];
                        end else if (op_q == OP_LOAD_START) begin
                            state_d = S_LOAD;
                            load_d  = 1'b1;
                        end else if (op_q == OP_PROC_START) begin
                            state_d = S_PROC;
                            sop_d   = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (op_q == OP_LOAD_WORD) begin
                            data_d  = pay_q;
                            valid_d = 1'b1;
                        end else if (op_q == OP_LOAD_END) begin
                            state_d = S_IDLE;
                            load_d  = 1'b0;
                        end
                    end
                end
                S_PROC: begin
                    if (i_EoP) begin
                        state_d = S_READ;
                        sop_d   = 1'b0;
                    end
                end
                S_READ: begin
                    // rd_stg_q[0] marks the cycle right after an increment
                    if (rd_stg_q[0] && cnt_q == len_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (accept && op_q == OP_READ_WORD) begin
                        valid_d     = 1'b1;
                        cnt_d       = cnt_q + NB_IMAGE'(1);
                        rd_stg_d[0] = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            pay_q     <= '0;
            en_q      <= 1'b0;
            en_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            eop_q     <= 1'b0;
            load_q    <= 1'b0;
            sop_q     <= 1'b0;
            valid_q   <= 1'b0;
            len_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            rd_stg_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pay_q     <= pay_d;
            en_q      <= en_d;
            en_prev_q <= en_prev_d;
            armed_q   <= armed_d;
            eop_q     <= eop_d;
            load_q    <= load_d;
            sop_q     <= sop_d;
            valid_q   <= valid_d;
            len_q     <= len_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            rd_stg_q  <= rd_stg_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        o_gpio_data                = '0;
        o_gpio_data[31]            = eop_q;
        o_gpio_data[30:29]         = state_q;
        o_gpio_data[NB_DATA-1:0]   = rdata_q;
    end

    assign o_load      = load_q;
    assign o_SoP       = sop_q;
    assign o_valid     = valid_q;
    assign o_imgLength = len_q;
    assign o_dataToMem = data_q;

endmodule

// File: doc/micro_ctrl_if.md
MICRO_CTRL_IF -- requirements
Module: micro_ctrl_if

Interface
REQ-001 The block SHALL have parameter NB_GPIO, default 32, GPIO command/status word width.
REQ-002 The block SHALL have parameter NB_DATA, default 13, pixel data width to/from memories.
REQ-003 The block SHALL have parameter NB_IMAGE, default 10, image length field width.
REQ-004 The block SHALL have port i_CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port i_gpio_data  input  NB_GPIO  command word from processor.
REQ-007 The block SHALL have port i_EoP  input  1  end-of-process flag from the downstream FSM.
REQ-008 The block SHALL have port i_readData  input  NB_DATA  pixel read back from the result memory.
REQ-009 The block SHALL have port o_gpio_data  output  NB_GPIO  status/readback word to processor.
REQ-010 The block SHALL have port o_load  output  1  load-phase level to the FSM.
REQ-011 The block SHALL have port o_SoP  output  1  start-of-process level to the FSM.
REQ-012 The block SHALL have port o_valid  output  1  one-cycle word strobe to the FSM.
REQ-013 The block SHALL have port o_imgLength  output  NB_IMAGE  latched image length.
REQ-014 The block SHALL have port o_dataToMem  output  NB_DATA  pixel word to load into memory.

Function
REQ-015 Command fields: [31:29] opcode, [23] enable, [NB_DATA-1:0] payload; all other bits ignored.
REQ-016 A command SHALL be accepted only on the cycle its registered enable bit shows a 0->1 transition (previous 0, current 1); one accept per edge.
REQ-017 Opcodes: 001 SET_LEN, 010 LOAD_START, 011 LOAD_WORD, 100 LOAD_END, 101 PROC_START, 110 READ_WORD, 111 SOFT_RST; 000 and opcodes illegal in the current state SHALL be ignored with no output change.
REQ-018 States: IDLE, LOAD, PROC, READ; the state after reset SHALL be IDLE.
REQ-019 IDLE: SET_LEN SHALL latch payload[NB_IMAGE-1:0] into o_imgLength next cycle; LOAD_START -> LOAD with o_load=1 next cycle; PROC_START -> PROC with o_SoP=1 next cycle.
REQ-020 LOAD: LOAD_WORD SHALL register payload onto o_dataToMem and assert o_valid for exactly one cycle, both on the cycle after accept; LOAD_END SHALL deassert o_load and return to IDLE next cycle.
REQ-021 o_dataToMem SHALL hold its last value when no LOAD_WORD is accepted.
REQ-022 PROC: o_SoP SHALL stay 1 until i_EoP is sampled 1, then o_SoP=0 and the state -> READ next cycle; all commands except SOFT_RST ignored in PROC.
REQ-023 READ: READ_WORD SHALL assert o_valid for one cycle (cycle after accept) and increment an NB_IMAGE-bit read counter.
REQ-024 READ: i_readData SHALL be captured into o_gpio_data[NB_DATA-1:0] two cycles after the o_valid pulse (memory latency of one cycle plus one register stage).
REQ-025 READ: when the read counter equals o_imgLength after an increment, the block SHALL return to IDLE and clear the counter on the next cycle.
REQ-026 o_gpio_data[31] SHALL equal the registered i_EoP; [30:29] SHALL report the state encoding (IDLE=00, LOAD=01, PROC=10, READ=11); remaining upper bits 0.
REQ-027 SOFT_RST accepted in any state SHALL return to IDLE next cycle with o_load, o_SoP, o_valid and the read counter cleared; o_imgLength and o_dataToMem retained.
REQ-028 o_load and o_SoP SHALL never be 1 simultaneously; o_valid SHALL never be asserted in IDLE or PROC.
REQ-029 A second enable edge arriving while o_valid is still high SHALL be accepted normally, giving back-to-back one-cycle pulses separated by at least one low cycle (the enable bit must drop between edges).

Reset
REQ-030 While i_reset=0, asynchronously: state IDLE, o_load=0, o_SoP=0, o_valid=0, o_imgLength=0, o_dataToMem=0, o_gpio_data=0, read counter 0, registered enable bit 0.
REQ-031 Reset asserted mid-LOAD, mid-PROC or mid-READ SHALL abort immediately; after release the first enable edge is detected only after the enable bit has been sampled 0.

Verification
REQ-032 SET_LEN payload 10'd8 -> o_imgLength=8 one cycle after accept; o_gpio_data[30:29]=00.
REQ-033 LOAD_START, 3x LOAD_WORD (payloads 0x0A5,0x1FF,0x000), LOAD_END -> o_load high throughout, 3 single-cycle o_valid pulses with o_dataToMem 0x0A5,0x1FF,0x000, o_load=0 after LOAD_END.
REQ-034 Enable held high for 20 cycles with LOAD_WORD -> exactly one o_valid pulse.
REQ-035 PROC_START, i_EoP raised 50 cycles later -> o_SoP high 50 cycles, then 0; state reads 11; READ_WORD ignored during PROC.
REQ-036 Length 4, 4x READ_WORD with i_readData=0x100+n -> o_gpio_data[12:0] tracks each value 2 cycles after each pulse; state returns to IDLE after the 4th.
REQ-037 SOFT_RST mid-READ, then i_reset=0 mid-LOAD -> IDLE each time, outputs per REQ-027 and REQ-030.
